// File: rtl/axi_demux_id_tracker.sv
// -----------------------------------------------------------------------------
// axi_demux_id_tracker
//
// Tracks outstanding AXI transactions per (truncated) ID for a demultiplexer.
// Each ID entry keeps a count of transactions in flight and the master port
// they were routed to. A new transaction on an ID that already has
// transactions in flight is held off when it targets a different port.
// Responses could otherwise return out of order across ports for the same ID.
//
// Ports
//   clk_i        : clock, all state updates on the rising edge
//   rst_ni       : synchronous active-low reset
//   req_valid_i  : AW/AR transaction offered
//   req_id_i     : lookup ID (low AxiLookBits of the AXI ID) of the offer
//   req_select_i : target master port of the offer
//   req_ready_o  : offer is accepted this cycle (independent of req_valid_i)
//   rsp_done_i   : last response beat (B, or R with last) completes this cycle
//   rsp_id_i     : lookup ID of the completing response
//   occupied_o   : entry req_id_i has transactions in flight
//   busy_o       : any entry has transactions in flight
//   err_o        : registered one-cycle pulse after an underflowing response
//                  or an offer with an out-of-range select
// -----------------------------------------------------------------------------
module axi_demux_id_tracker #(
    parameter int unsigned AxiLookBits = 3,
    parameter int unsigned NoMstPorts  = 4,
    parameter int unsigned MaxTrans    = 8,
    parameter int unsigned UniqueIds   = 0,
    localparam int unsigned SelectWidth = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1,
    localparam int unsigned CntWidth    = $clog2(MaxTrans + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    input  logic [AxiLookBits-1:0] req_id_i,
    input  logic [SelectWidth-1:0] req_select_i,
    output logic                   req_ready_o,
    input  logic                   rsp_done_i,
    input  logic [AxiLookBits-1:0] rsp_id_i,
    output logic                   occupied_o,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int unsigned NumIds = 2 ** AxiLookBits;
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTrans);
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    // Per-ID state
    logic [CntWidth-1:0]    cnt_q [NumIds];
    logic [CntWidth-1:0]    cnt_d [NumIds];
    logic [SelectWidth-1:0] sel_q [NumIds];
    logic [SelectWidth-1:0] sel_d [NumIds];
    logic                   err_q;
    logic                   err_d;

    // Lookup results for the offered request and the completing response
    logic [CntWidth-1:0]    req_cnt;
    logic [SelectWidth-1:0] req_sel;
    logic [CntWidth-1:0]    rsp_cnt;
    logic                   sel_legal;
    logic                   order_ok;
    logic                   accept;
    logic                   rsp_ok;
    logic                   any_busy;

    // Ready is built from registered state only; a response completing in the
    // same cycle does not free up the entry until the next cycle.
    always_comb begin
        req_cnt   = cnt_q[req_id_i];
        req_sel   = sel_q[req_id_i];
        rsp_cnt   = cnt_q[rsp_id_i];
        sel_legal = (32'(req_select_i) < NoMstPorts);
        order_ok  = (req_cnt == '0) || (req_sel == req_select_i) || (UniqueIds != 0);

        req_ready_o = sel_legal && (req_cnt != CntMax) && order_ok;
        accept      = req_valid_i && req_ready_o;
        rsp_ok      = rsp_done_i && (rsp_cnt != '0);

        occupied_o = (req_cnt != '0);
    end

    always_comb begin
        any_busy = 1'b0;
        for (int i = 0; i < NumIds; i++) begin
            any_busy = any_busy | (cnt_q[i] != '0);
        end
        busy_o = any_busy;
    end

    // Next-state per entry. An acceptance and a completion on the same ID
    // cancel out. The select is only captured when an idle entry is opened;
    // a completion can never hit an idle entry, so the cancel case never
    // reloads it.
    always_comb begin
        for (int i = 0; i < NumIds; i++) begin
            logic inc;
            logic dec;
            inc      = accept && (req_id_i == AxiLookBits'(i));
            dec      = rsp_ok && (rsp_id_i == AxiLookBits'(i));
            cnt_d[i] = cnt_q[i];
            sel_d[i] = sel_q[i];
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CntOne;
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - CntOne;
            end
            if (inc && (cnt_q[i] == '0)) begin
                sel_d[i] = req_select_i;
            end
        end
    end

    // Protocol violations: completion on an idle entry, or an offer to a port
    // that does not exist. Reported one cycle later as a single-cycle pulse.
    always_comb begin
        err_d = (rsp_done_i && (rsp_cnt == '0)) || (req_valid_i && !sel_legal);
    end

    // Reset discards everything in flight and any pending violation.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumIds; i++) begin
                cnt_q[i] <= '0;
                sel_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NumIds; i++) begin
                cnt_q[i] <= cnt_d[i];
                sel_q[i] <= sel_d[i];
            end
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_axi_demux_id_tracker.sv
module tb_axi_demux_id_tracker;

    logic       clk;
    logic       rst_n;

    // Instance A: defaults (4 ports, MaxTrans 8, ordering enforced)
    logic       a_valid;
    logic [2:0] a_id;
    logic [1:0] a_sel;
    logic       a_ready;
    logic       a_done;
    logic [2:0] a_rsp_id;
    logic       a_occ;
    logic       a_busy;
    logic       a_err;

    // Instance B: 3 ports, unique IDs
    logic       b_valid;
    logic [2:0] b_id;
    logic [1:0] b_sel;
    logic       b_ready;
    logic       b_done;
    logic [2:0] b_rsp_id;
    logic       b_occ;
    logic       b_busy;
    logic       b_err;

    axi_demux_id_tracker #(
        .AxiLookBits(3),
        .NoMstPorts (4),
        .MaxTrans   (8),
        .UniqueIds  (0)
    ) dut_a (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (a_valid),
        .req_id_i    (a_id),
        .req_select_i(a_sel),
        .req_ready_o (a_ready),
        .rsp_done_i  (a_done),
        .rsp_id_i    (a_rsp_id),
        .occupied_o  (a_occ),
        .busy_o      (a_busy),
        .err_o       (a_err)
    );

    axi_demux_id_tracker #(
        .AxiLookBits(3),
        .NoMstPorts (3),
        .MaxTrans   (8),
        .UniqueIds  (1)
    ) dut_b (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (b_valid),
        .req_id_i    (b_id),
        .req_select_i(b_sel),
        .req_ready_o (b_ready),
        .rsp_done_i  (b_done),
        .rsp_id_i    (b_rsp_id),
        .occupied_o  (b_occ),
        .busy_o      (b_busy),
        .err_o       (b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string tag;
        logic  exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_err = 0;
    int  n_chk = 0;

    task automatic push(input string tag, input logic exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic chk(input logic obs);
        sb_t e;
        n_chk++;
        if (sb_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed=%b required=<entry>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                n_err++;
                $error("FAIL %s: observed=%b required=%b", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        a_valid = 1'b0; a_id = '0; a_sel = '0; a_done = 1'b0; a_rsp_id = '0;
        b_valid = 1'b0; b_id = '0; b_sel = '0; b_done = 1'b0; b_rsp_id = '0;
        tick();
        tick();
        rst_n = 1'b1;
        settle();

        // Reset state
        push("rst_busy_a", 1'b0);  chk(a_busy);
        push("rst_err_a", 1'b0);   chk(a_err);
        push("rst_occ_a", 1'b0);   chk(a_occ);
        push("rst_ready_a", 1'b1); chk(a_ready);
        push("rst_busy_b", 1'b0);  chk(b_busy);

        // Same-ID ordering: ID 2 to port 1, then ID 2 to port 3
        a_valid = 1'b1; a_id = 3'd2; a_sel = 2'd1;
        settle();
        push("ord_first_ready", 1'b1); chk(a_ready);
        tick();
        a_sel = 2'd3;
        settle();
        push("ord_mismatch_ready", 1'b0); chk(a_ready);
        push("ord_occupied", 1'b1);       chk(a_occ);
        tick();
        push("ord_still_stalled", 1'b0);  chk(a_ready);
        push("ord_no_err", 1'b0);         chk(a_err);
        a_done = 1'b1; a_rsp_id = 3'd2;
        settle();
        push("ord_no_bypass", 1'b0);      chk(a_ready);
        tick();
        a_done = 1'b0;
        settle();
        push("ord_ready_after_drain", 1'b1); chk(a_ready);
        push("ord_drain_no_err", 1'b0);      chk(a_err);
        tick();
        a_valid = 1'b0; a_sel = 2'd1;
        settle();
        push("ord_sel3_blocks_port1", 1'b0); chk(a_ready);
        a_sel = 2'd3;
        settle();
        push("ord_sel3_allows_port3", 1'b1); chk(a_ready);
        a_done = 1'b1; a_rsp_id = 3'd2;
        tick();
        a_done = 1'b0;
        settle();
        push("ord_final_idle", 1'b0); chk(a_busy);

        // Full counter on ID 5
        a_valid = 1'b1; a_id = 3'd5; a_sel = 2'd0;
        for (int i = 0; i < 8; i++) begin
            settle();
            push("full_accept_ready", 1'b1); chk(a_ready);
            tick();
        end
        settle();
        push("full_ninth_ready", 1'b0); chk(a_ready);
        push("full_no_err", 1'b0);      chk(a_err);
        tick();
        push("full_still_blocked", 1'b0); chk(a_ready);
        a_done = 1'b1; a_rsp_id = 3'd5;
        settle();
        push("full_no_bypass", 1'b0); chk(a_ready);
        tick();
        a_done = 1'b0;
        settle();
        push("full_ready_restored", 1'b1); chk(a_ready);
        a_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            a_done = 1'b1; a_rsp_id = 3'd5;
            tick();
        end
        a_done = 1'b0;
        settle();
        push("full_drained_busy", 1'b0); chk(a_busy);
        push("full_drained_err", 1'b0);  chk(a_err);

        // Simultaneous accept and complete on ID 1 holding 3
        a_valid = 1'b1; a_id = 3'd1; a_sel = 2'd0;
        tick();
        tick();
        tick();
        a_done = 1'b1; a_rsp_id = 3'd1;
        settle();
        push("sim_ready", 1'b1); chk(a_ready);
        tick();
        a_valid = 1'b0; a_done = 1'b0;
        settle();
        push("sim_busy", 1'b1); chk(a_busy);
        push("sim_err", 1'b0);  chk(a_err);
        push("sim_occ", 1'b1);  chk(a_occ);
        a_done = 1'b1; a_rsp_id = 3'd1;
        tick();
        tick();
        a_done = 1'b0;
        settle();
        push("sim_occ_after_two", 1'b1); chk(a_occ);
        // Third completion on ID 1 alongside an acceptance on ID 6
        a_done = 1'b1; a_rsp_id = 3'd1;
        a_valid = 1'b1; a_id = 3'd6; a_sel = 2'd2;
        settle();
        push("diff_ready_id6", 1'b1); chk(a_ready);
        tick();
        a_done = 1'b0; a_valid = 1'b0; a_id = 3'd1;
        settle();
        push("diff_id1_empty", 1'b0); chk(a_occ);
        a_id = 3'd6;
        settle();
        push("diff_id6_occupied", 1'b1); chk(a_occ);
        push("diff_no_err", 1'b0);       chk(a_err);

        // Reset mid-operation with IDs 0, 3, 7 (and 6) outstanding
        a_valid = 1'b1; a_sel = 2'd0; a_id = 3'd0;
        tick();
        a_id = 3'd3;
        tick();
        a_id = 3'd7;
        tick();
        a_valid = 1'b0;
        settle();
        push("mid_busy_before", 1'b1); chk(a_busy);
        rst_n = 1'b0;
        a_done = 1'b1; a_rsp_id = 3'd4;
        a_valid = 1'b1; a_id = 3'd2; a_sel = 2'd0;
        tick();
        rst_n = 1'b1; a_done = 1'b0; a_valid = 1'b0;
        settle();
        push("mid_busy_after", 1'b0); chk(a_busy);
        push("mid_err_after", 1'b0);  chk(a_err);
        for (int i = 0; i < 8; i++) begin
            a_id = 3'(i);
            settle();
            push("mid_occ_cleared", 1'b0); chk(a_occ);
        end
        tick();
        push("mid_err_next", 1'b0); chk(a_err);

        // Underflow on idle ID 4 (3-port instance)
        b_done = 1'b1; b_rsp_id = 3'd4;
        tick();
        b_done = 1'b0;
        settle();
        push("unf_err_pulse", 1'b1); chk(b_err);
        push("unf_busy", 1'b0);      chk(b_busy);
        tick();
        push("unf_err_clear", 1'b0); chk(b_err);

        // Illegal select 3 with only 3 ports
        b_valid = 1'b1; b_id = 3'd0; b_sel = 2'd3;
        settle();
        push("ill_ready", 1'b0); chk(b_ready);
        tick();
        b_valid = 1'b0;
        settle();
        push("ill_err_pulse", 1'b1); chk(b_err);
        push("ill_busy", 1'b0);      chk(b_busy);
        tick();
        push("ill_err_clear", 1'b0); chk(b_err);

        // Unique IDs: ID 0 to port 0 then port 2, back-to-back
        b_valid = 1'b1; b_id = 3'd0; b_sel = 2'd0;
        settle();
        push("uniq_first_ready", 1'b1); chk(b_ready);
        tick();
        b_sel = 2'd2;
        settle();
        push("uniq_second_ready", 1'b1); chk(b_ready);
        tick();
        b_valid = 1'b0;
        settle();
        push("uniq_occ", 1'b1); chk(b_occ);
        b_done = 1'b1; b_rsp_id = 3'd0;
        tick();
        push("uniq_occ_after_one", 1'b1); chk(b_occ);
        tick();
        b_done = 1'b0;
        settle();
        push("uniq_occ_after_two", 1'b0); chk(b_occ);
        push("uniq_no_err", 1'b0);        chk(b_err);
        tick();
        push("uniq_no_err_next", 1'b0);   chk(b_err);

        if (sb_q.size() != 0) begin
            n_err++;
            $error("FAIL scoreboard_leftover: observed=%0d required=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
